wrapper_shift_update_reg: RTL

- Parametrised successor to the team's 12-bit parallel-in/serial-out shifter.
- Provides parallel capture, bidirectional serial shift with serial input, and a shadow update register that drives stable parallel outputs.
- Counts shifted bits since the last capture and flags frame completion.
- Used as a generic wrapper boundary/data register segment in the IEEE 1500 test wrapper; segments chain through si/so.

---
 rtl/wrapper_shift_update_reg.sv | 79 +++++++
 1 files changed

// File: rtl/wrapper_shift_update_reg.sv
// Wrapper boundary/data register segment: parallel capture, bidirectional
// serial shift, shadow update register, shift counter and frame flag.
module wrapper_shift_update_reg #(
    parameter int               WIDTH     = 12,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             capture,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             si,
    input  logic             update,
    output logic             so,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    shift_count,
    output logic             frame_done
);

    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    count_next;
    logic             shift_ok;

    // A shift is only accepted when no capture competes for the register.
    assign shift_ok = shift_en & ~capture;

    // Serial output is taken from whichever end the current direction empties.
    assign so = dir ? shift_reg[WIDTH-1] : shift_reg[0];

    // Next shift count: cleared by capture, saturating at WIDTH.
    always_comb begin
        count_next = shift_count;
        if (capture) begin
            count_next = '0;
        end else if (shift_ok && (shift_count != FULL)) begin
            count_next = shift_count + CW'(1);
        end
    end

    // Shift register: capture has priority over shifting in either direction.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shift_reg <= RESET_VAL;
        end else if (capture) begin
            shift_reg <= data_in;
        end else if (shift_en) begin
            if (dir) begin
                shift_reg <= {shift_reg[WIDTH-2:0], si};
            end else begin
                shift_reg <= {si, shift_reg[WIDTH-1:1]};
            end
        end
    end

    // Update register samples the pre-edge shift register contents.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            data_out <= RESET_VAL;
        end else if (update) begin
            data_out <= shift_reg;
        end
    end

    // Counter and registered frame flag move together so they always agree.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shift_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            shift_count <= count_next;
            frame_done  <= (count_next == FULL);
        end
    end

endmodule
